// File: rtl/uart_pkg.sv
// Shared constants and types for the UART controller: register map, LSR layout
// and the state encoding common to the receive and transmit sequencers.
package uart_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_LSR  = 3'd5;

  localparam int LSR_RX_AVAIL  = 0;
  localparam int LSR_OVERRUN   = 1;
  localparam int LSR_FRAME_ERR = 3;
  localparam int LSR_TX_IDLE   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [7:0] lsr_pack(input logic rx_avail, input logic overrun,
                                          input logic frame_err, input logic tx_idle);
    logic [7:0] v;
    v                = 8'h00;
    v[LSR_RX_AVAIL]  = rx_avail;
    v[LSR_OVERRUN]   = overrun;
    v[LSR_FRAME_ERR] = frame_err;
    v[LSR_TX_IDLE]   = tx_idle;
    return v;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO. Pointers carry one extra MSB so full and empty are distinct;
// a push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  // Occupancy flags, accepted transfers and head-of-queue data
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    head      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_ctrl.sv
// 8N1 UART with a two-register bus interface (DATA, LSR), a synchronized receiver
// feeding a small FIFO, and an unbuffered transmitter.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       txd,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic        rxd_meta_r, rxd_sync_r, rxd_prev_r;
  uart_state_e rx_state_r;
  logic [CW-1:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_push_r, rx_ferr_r, rx_brk_r;

  uart_state_e tx_state_r;
  logic [CW-1:0] tx_cnt_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;
  logic        txd_r;

  logic        ack_r;
  logic [7:0]  rdata_r;
  logic        overrun_r, frame_err_r;

  logic        fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [7:0]  fifo_head_s;
  logic        rd_data_s, rd_lsr_s, wr_data_s;

  assign txd   = txd_r;
  assign ack   = ack_r;
  assign rdata = rdata_r;

  // Bus access decode; a DATA read pops on the same edge that raises ack
  always_comb begin
    rd_data_s  = req & ~we & (addr == ADDR_DATA);
    rd_lsr_s   = req & ~we & (addr == ADDR_LSR);
    wr_data_s  = req & we & (addr == ADDR_DATA);
    fifo_pop_s = rd_data_s & ~fifo_empty_s;
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Receive sequencer; after a bad stop bit it parks in STOP until the line is high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= '0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_push_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_brk_r   <= 1'b0;
    end else begin
      rx_push_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      case (rx_state_r)
        ST_IDLE: begin
          rx_cnt_r <= '0;
          if (rxd_prev_r & ~rxd_sync_r) rx_state_r <= ST_START;
        end
        ST_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rxd_sync_r ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (rx_cnt_r == DIV_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (rx_brk_r) begin
            if (rxd_sync_r) begin
              rx_brk_r   <= 1'b0;
              rx_state_r <= ST_IDLE;
            end
          end else if (rx_cnt_r == DIV_LAST) begin
            rx_cnt_r <= '0;
            if (rxd_sync_r) begin
              rx_push_r  <= 1'b1;
              rx_state_r <= ST_IDLE;
            end else begin
              rx_ferr_r <= 1'b1;
              rx_brk_r  <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_ONE;
          end
        end
        default: rx_state_r <= ST_IDLE;
      endcase
    end
  end

  // Transmit sequencer; txd is driven straight from this register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        ST_IDLE: begin
          tx_cnt_r <= '0;
          if (wr_data_s) begin
            tx_shift_r <= wdata;
            txd_r      <= 1'b0;
            tx_state_r <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_r == DIV_LAST) begin
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            txd_r      <= tx_shift_r[0];
            tx_state_r <= ST_DATA;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (tx_cnt_r == DIV_LAST) begin
            tx_cnt_r <= '0;
            if (tx_bit_r == 3'd7) begin
              txd_r      <= 1'b1;
              tx_state_r <= ST_STOP;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              txd_r      <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (tx_cnt_r == DIV_LAST) begin
            tx_cnt_r   <= '0;
            tx_state_r <= ST_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + CNT_ONE;
          end
        end
        default: tx_state_r <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as an LSR read survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overrun_r   <= (overrun_r & ~rd_lsr_s) | (rx_push_r & fifo_full_s & ~fifo_pop_s);
      frame_err_r <= (frame_err_r & ~rd_lsr_s) | rx_ferr_r;
    end
  end

  // Bus response: ack one cycle after req, rdata updated only on reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      ack_r <= req;
      if (req & ~we) begin
        case (addr)
          ADDR_DATA: rdata_r <= fifo_empty_s ? 8'h00 : fifo_head_s;
          ADDR_LSR:  rdata_r <= lsr_pack(~fifo_empty_s, overrun_r, frame_err_r,
                                         tx_state_r == ST_IDLE);
          default:   rdata_r <= 8'h00;
        endcase
      end
    end
  end

  uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_r),
    .push_data (rx_shift_r),
    .pop       (fifo_pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

endmodule
